// File: rtl/register_file_sb.sv
// Register file with two combinational read ports, one write port, optional write-through
// bypass, optional hardwired-zero R0 and a per-register pending-write scoreboard.
module register_file_sb #(
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      Ra,
  input  logic [ADDR_W-1:0]      Rb,
  output logic [WIDTH-1:0]       BusA,
  output logic [WIDTH-1:0]       BusB,
  input  logic [ADDR_W-1:0]      Rw,
  input  logic                   enWrite,
  input  logic [WIDTH-1:0]       BusW,
  input  logic                   resvEn,
  input  logic [ADDR_W-1:0]      resvReg,
  output logic                   stallA,
  output logic                   stallB,
  output logic [(2**ADDR_W)-1:0] pendMask,
  output logic                   errDbl
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam bit          ZeroEn  = (ZERO_REG != 0);
  localparam bit          BypEn   = (BYPASS != 0);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic             err_dbl_q, err_dbl_d;

  logic wr_eff, rs_eff;
  logic byp_a, byp_b;

  assign wr_eff = enWrite && !(ZeroEn && (Rw == '0));
  assign rs_eff = resvEn && !(ZeroEn && (resvReg == '0));

  // The write clears pending first so a same-cycle reservation for the new producer wins.
  always_comb begin
    regs_d    = regs_q;
    pend_d    = pend_q;
    err_dbl_d = err_dbl_q;
    if (wr_eff) begin
      regs_d[Rw] = BusW;
      pend_d[Rw] = 1'b0;
    end
    if (rs_eff) begin
      pend_d[resvReg] = 1'b1;
      if (pend_q[resvReg] && !(wr_eff && (Rw == resvReg))) begin
        err_dbl_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pend_q    <= '0;
      err_dbl_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      pend_q    <= pend_d;
      err_dbl_q <= err_dbl_d;
    end
  end

  assign byp_a = BypEn && wr_eff && (Rw == Ra);
  assign byp_b = BypEn && wr_eff && (Rw == Rb);

  always_comb begin
    BusA = regs_q[Ra];
    if (byp_a) begin
      BusA = BusW;
    end
    if (ZeroEn && (Ra == '0)) begin
      BusA = '0;
    end
  end

  always_comb begin
    BusB = regs_q[Rb];
    if (byp_b) begin
      BusB = BusW;
    end
    if (ZeroEn && (Rb == '0)) begin
      BusB = '0;
    end
  end

  assign stallA   = pend_q[Ra] && !byp_a;
  assign stallB   = pend_q[Rb] && !byp_b;
  assign pendMask = pend_q;
  assign errDbl   = err_dbl_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench: one bypassing and one non-bypassing instance share stimulus and are
// checked every cycle against a behavioural model of the register file.
module tb_register_file_sb;

  localparam int unsigned W  = 24;
  localparam int unsigned AW = 3;
  localparam int unsigned D  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ra, rb, rw, resv_reg;
  logic          en_write, resv_en;
  logic [W-1:0]  bus_w;

  logic [W-1:0]  bus_a_1, bus_b_1, bus_a_0, bus_b_0;
  logic          stall_a_1, stall_b_1, stall_a_0, stall_b_0;
  logic [D-1:0]  pend_1, pend_0;
  logic          err_1, err_0;

  always #5 clk = ~clk;

  register_file_sb #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) u_dut_byp (
    .clk(clk), .reset(reset), .Ra(ra), .Rb(rb), .BusA(bus_a_1), .BusB(bus_b_1),
    .Rw(rw), .enWrite(en_write), .BusW(bus_w), .resvEn(resv_en), .resvReg(resv_reg),
    .stallA(stall_a_1), .stallB(stall_b_1), .pendMask(pend_1), .errDbl(err_1)
  );

  register_file_sb #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) u_dut_nobyp (
    .clk(clk), .reset(reset), .Ra(ra), .Rb(rb), .BusA(bus_a_0), .BusB(bus_b_0),
    .Rw(rw), .enWrite(en_write), .BusW(bus_w), .resvEn(resv_en), .resvReg(resv_reg),
    .stallA(stall_a_0), .stallB(stall_b_0), .pendMask(pend_0), .errDbl(err_0)
  );

  typedef struct {
    logic [W-1:0] bus_a1, bus_b1, bus_a0, bus_b0;
    logic         st_a1, st_b1, st_a0, st_b0;
    logic [D-1:0] pend;
    logic         err;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_regs [D];
  logic [D-1:0] m_pend;
  logic         m_err;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic m_wr_eff();
    return en_write && (rw != 0);
  endfunction

  function automatic logic [W-1:0] m_read(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && m_wr_eff() && (rw == a)) return bus_w;
    return m_regs[a];
  endfunction

  function automatic logic m_stall(input logic [AW-1:0] a, input bit byp);
    return m_pend[a] && !(byp && m_wr_eff() && (rw == a));
  endfunction

  task automatic model_edge();
    logic rs_eff;
    rs_eff = resv_en && (resv_reg != 0);
    if (reset) begin
      for (int i = 0; i < D; i++) m_regs[i] = '0;
      m_pend = '0;
      m_err  = 1'b0;
    end else begin
      if (rs_eff && m_pend[resv_reg] && !(m_wr_eff() && (rw == resv_reg))) m_err = 1'b1;
      if (m_wr_eff()) begin
        m_regs[rw] = bus_w;
        m_pend[rw] = 1'b0;
      end
      if (rs_eff) m_pend[resv_reg] = 1'b1;
    end
  endtask

  // Inputs are already applied; push the expectation, compare mid-cycle, then take the edge.
  task automatic step();
    exp_t e;
    e.bus_a1 = m_read(ra, 1'b1);
    e.bus_b1 = m_read(rb, 1'b1);
    e.bus_a0 = m_read(ra, 1'b0);
    e.bus_b0 = m_read(rb, 1'b0);
    e.st_a1  = m_stall(ra, 1'b1);
    e.st_b1  = m_stall(rb, 1'b1);
    e.st_a0  = m_stall(ra, 1'b0);
    e.st_b0  = m_stall(rb, 1'b0);
    e.pend   = m_pend;
    e.err    = m_err;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq("busA_byp",    32'(bus_a_1),   32'(e.bus_a1));
    check_eq("busB_byp",    32'(bus_b_1),   32'(e.bus_b1));
    check_eq("busA_nobyp",  32'(bus_a_0),   32'(e.bus_a0));
    check_eq("busB_nobyp",  32'(bus_b_0),   32'(e.bus_b0));
    check_eq("stallA_byp",  32'(stall_a_1), 32'(e.st_a1));
    check_eq("stallB_byp",  32'(stall_b_1), 32'(e.st_b1));
    check_eq("stallA_nobyp", 32'(stall_a_0), 32'(e.st_a0));
    check_eq("stallB_nobyp", 32'(stall_b_0), 32'(e.st_b0));
    check_eq("pend_byp",    32'(pend_1),    32'(e.pend));
    check_eq("pend_nobyp",  32'(pend_0),    32'(e.pend));
    check_eq("err_byp",     32'(err_1),     32'(e.err));
    check_eq("err_nobyp",   32'(err_0),     32'(e.err));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic rst, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic we, input logic [AW-1:0] w, input logic [W-1:0] d,
                       input logic rv, input logic [AW-1:0] rr);
    reset = rst; ra = a; rb = b; en_write = we; rw = w; bus_w = d;
    resv_en = rv; resv_reg = rr;
    step();
  endtask

  task automatic idle(input logic [AW-1:0] a, input logic [AW-1:0] b);
    drive(1'b0, a, b, 1'b0, 3'd0, 24'h0, 1'b0, 3'd0);
  endtask

  initial begin
    reset = 1'b1; ra = '0; rb = '0; rw = '0; en_write = 1'b0; bus_w = '0;
    resv_en = 1'b0; resv_reg = '0;
    for (int i = 0; i < D; i++) m_regs[i] = '0;
    m_pend = '0;
    m_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state across all address pairs
    for (int i = 0; i < D; i++) idle(3'(i), 3'(D - 1 - i));

    // Write R3 with bypass, then read from storage
    drive(1'b0, 3'd3, 3'd4, 1'b1, 3'd3, 24'hABCDEF, 1'b0, 3'd0);
    idle(3'd3, 3'd3);

    // R0 is hardwired: write and reserve ignored
    drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 24'hFFFFFF, 1'b1, 3'd0);
    idle(3'd0, 3'd0);

    // Reserve R5, observe stall, writeback releases it
    drive(1'b0, 3'd5, 3'd5, 1'b0, 3'd0, 24'h0, 1'b1, 3'd5);
    idle(3'd1, 3'd5);
    drive(1'b0, 3'd1, 3'd5, 1'b1, 3'd5, 24'h000123, 1'b0, 3'd0);
    idle(3'd5, 3'd5);

    // Double reservation of R2 sets sticky error
    drive(1'b0, 3'd2, 3'd2, 1'b0, 3'd0, 24'h0, 1'b1, 3'd2);
    drive(1'b0, 3'd2, 3'd2, 1'b0, 3'd0, 24'h0, 1'b1, 3'd2);
    for (int i = 0; i < 10; i++) idle(3'(i), 3'd2);

    // Reserve and write the same register in one cycle: no error, pend stays set
    drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 24'h0, 1'b0, 3'd0);
    drive(1'b0, 3'd2, 3'd2, 1'b0, 3'd0, 24'h0, 1'b1, 3'd2);
    drive(1'b0, 3'd2, 3'd2, 1'b1, 3'd2, 24'h55AA55, 1'b1, 3'd2);
    idle(3'd2, 3'd2);

    // Reset mid-operation drops reservations and the concurrent write
    drive(1'b0, 3'd1, 3'd6, 1'b0, 3'd0, 24'h0, 1'b1, 3'd1);
    drive(1'b0, 3'd1, 3'd6, 1'b0, 3'd0, 24'h0, 1'b1, 3'd6);
    drive(1'b1, 3'd1, 3'd6, 1'b1, 3'd1, 24'h777777, 1'b1, 3'd3);
    idle(3'd1, 3'd6);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0), 3'($urandom), 3'($urandom),
            1'($urandom), 3'($urandom), 24'($urandom),
            ($urandom_range(0, 3) == 0), 3'($urandom));
    end

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
